freq_meter_ctrl: RTL and testbench
==================================

// Module: freq_meter_ctrl
// PURPOSE
//  Measurement sequencer for the frequency meter datapath.
//  Opens a counting gate of selectable length on the BCD event counter, lets the counter settle,
//  then pulses the display latch lock low for one cycle to capture the count. The displayed value
//  is then held and the counter cleared before the next window. Sits between the clock-divider
//  timebase and the counter / 16-bit display latch pair.
// PARAMETERS
//  GATE_BASE      50000  clk cycles in shortest gate (range 0); 1 ms at 50 MHz
//  SETTLE_CYCLES  2      gate-closed cycles before latching (counter/sync settle)
//  HOLD_CYCLES    50000  cycles the latched value is held before the next window
//  TW             26     timer width; must hold GATE_BASE*1000 and HOLD_CYCLES
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  enable     in   1   1 = run continuous measurements, 0 = stop/abort
//  range_sel  in   2   gate length = GATE_BASE * 10^range_sel
//  cnt_ovf    in   1   counter overflow (carry out of digit 3), level or pulse
//  cnt_en     out  1   counter count enable (gate open)
//  cnt_clr    out  1   synchronous clear to counter
//  lock       out  1   to display latch: 0 = load count, 1 = hold
//  meas_done  out  1   one-cycle pulse per completed measurement
//  ovf        out  1   overflow flag for the currently displayed value
//  range_act  out  2   range used for the currently displayed value
// BEHAVIOUR
//  - All outputs registered. Reset values: cnt_en=0, cnt_clr=1, lock=1, meas_done=0, ovf=0, range_act=0; state IDLE.
//  - States: IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD.
//  - IDLE: cnt_clr=1, lock=1, cnt_en=0. enable=1 -> CLEAR.
//  - CLEAR (1 cycle): cnt_clr=1; capture range_sel into range_q; clear ovf_pend; load timer -> GATE.
//  - GATE: cnt_en=1 for exactly GATE_BASE*10^range_q cycles. Range multipliers are constants 1/10/100/1000; no runtime multiply.
//    cnt_ovf=1 in any GATE cycle sets sticky ovf_pend.
//    Timer expiry -> SETTLE.
//  - SETTLE: cnt_en=0 for SETTLE_CYCLES cycles -> LATCH. SETTLE_CYCLES=0 goes straight to LATCH.
//  - LATCH (1 cycle): lock=0. Same edge: ovf<=ovf_pend, range_act<=range_q.
//    meas_done=1 in the first HOLD cycle only -> HOLD.
//  - HOLD: lock=1, cnt_en=0 for HOLD_CYCLES cycles. Then enable=1 -> CLEAR, else -> IDLE.
//  - cnt_clr is 1 only in IDLE and CLEAR. lock is 0 only in LATCH.
//  - enable=0 in CLEAR/GATE/SETTLE: abort to IDLE next cycle. No LATCH, no meas_done; ovf/range_act keep old values.
//    enable=0 in LATCH: LATCH completes. enable=0 in HOLD: HOLD completes, then -> IDLE.
//  - range_sel changes outside CLEAR: ignored until the next CLEAR.
//  - Timer is a down-counter: load N-1, expire at 0. No wrap; it reloads on each state entry.
//  - rst_n low at any time (e.g. mid-GATE): immediate async return to reset values.
//    First measurement after release starts from IDLE.
// STRUCTURE
//  - Shared package freq_meter_pkg.vh:
//    state encodings (3-bit localparams), RANGE_MULT constants {1,10,100,1000}, range width.
//  - One sub-module gate_timer: TW-bit loadable down-counter with load/value/expired.
//    Reused for GATE, SETTLE and HOLD intervals.
//  - FSM and output registers stay in freq_meter_ctrl.
// TESTING (bench params: GATE_BASE=4, SETTLE_CYCLES=2, HOLD_CYCLES=3, TW=16)
//  1. Reset: hold rst_n=0 then release, enable=0 -> cnt_en=0, cnt_clr=1, lock=1, meas_done=0, ovf=0,
//     range_act=0, stable indefinitely.
//  2. enable=1, range_sel=0 -> cnt_clr 1 cycle, cnt_en high exactly 4 cycles, 2 idle, lock=0 1 cycle,
//     meas_done 1 cycle, repeat period 11 cycles.
//  3. range_sel=2 -> cnt_en high exactly 400 consecutive cycles; range_act=2 after LATCH.
//  4. cnt_ovf pulse in 2nd GATE cycle -> ovf=1 from LATCH edge. Next window with no ovf -> ovf=0.
//  5. enable=0 in GATE cycle 3 -> IDLE next cycle, cnt_en=0, lock never 0, no meas_done.
//     range_sel change mid-GATE -> gate length unchanged.
//  6. rst_n pulse mid-GATE -> outputs go to reset values asynchronously (before next clk edge);
//     after release with enable=1 -> full sequence restarts from IDLE/CLEAR.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter measurement sequencer.
//   state_e     : sequencer state encoding (3-bit)
//   RANGE_W     : width of the gate range selector
//   RANGE_MULT  : gate length multiplier per range (1/10/100/1000)
package freq_meter_pkg;

  localparam int RANGE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LATCH  = 3'd4,
    ST_HOLD   = 3'd5
  } state_e;

  // Decade multipliers are constants so each gate length folds to a fixed
  // load value; no multiplier is built.
  localparam int unsigned RANGE_MULT [4] = '{1, 10, 100, 1000};

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter used for every timed interval of the sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (overrides counting)
//   load_val   : interval length minus one
//   expired    : counter has reached zero (stays at zero, never wraps)
module gate_timer #(
  parameter int TW = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] count_q;

  // NOTE: state registers use non-blocking assignments and reset
  // asynchronously, so every register in an edge-triggered block updates
  // together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/freq_meter_ctrl.sv
// Measurement sequencer for the frequency meter datapath.
// Opens a counting gate of GATE_BASE*10^range cycles on the BCD counter,
// waits for it to settle, pulses lock low for one cycle to load the display
// latch, holds the display, then clears the counter for the next window.
//   enable     : 1 = continuous measurements, 0 = stop/abort
//   range_sel  : gate range, sampled only while clearing the counter
//   cnt_ovf    : counter overflow, sticky over the gate window
//   cnt_en     : counter enable (gate open)
//   cnt_clr    : synchronous clear to the counter
//   lock       : display latch control, 0 = load, 1 = hold
//   meas_done  : one-cycle pulse per completed measurement
//   ovf        : overflow flag belonging to the displayed value
//   range_act  : range belonging to the displayed value
// All outputs are registered and decoded from the next state so they line
// up with the state they describe.
module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int GATE_BASE     = 50000,
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 50000,
  parameter int TW            = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [RANGE_W-1:0] range_sel,
  input  logic               cnt_ovf,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               lock,
  output logic               meas_done,
  output logic               ovf,
  output logic [RANGE_W-1:0] range_act
);

  // Timer load values are interval length minus one (expire at zero).
  localparam logic [TW-1:0] GATE_LOAD_R0 = TW'(GATE_BASE * RANGE_MULT[0] - 1);
  localparam logic [TW-1:0] GATE_LOAD_R1 = TW'(GATE_BASE * RANGE_MULT[1] - 1);
  localparam logic [TW-1:0] GATE_LOAD_R2 = TW'(GATE_BASE * RANGE_MULT[2] - 1);
  localparam logic [TW-1:0] GATE_LOAD_R3 = TW'(GATE_BASE * RANGE_MULT[3] - 1);
  localparam logic [TW-1:0] SETTLE_LOAD  = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  // HOLD always lasts at least one cycle, since meas_done is issued there.
  localparam logic [TW-1:0] HOLD_LOAD    = TW'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic               timer_load, timer_expired;
  logic [TW-1:0]      timer_load_val, gate_load_val;
  logic [RANGE_W-1:0] range_q, range_q_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               cnt_en_d, cnt_clr_d, lock_d, meas_done_d, ovf_d;
  logic [RANGE_W-1:0] range_act_d;

  gate_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .expired  (timer_expired)
  );

  // The gate is loaded on the CLEAR edge, the same edge that captures
  // range_sel, so the live input selects the load value here.
  always_comb begin
    unique case (range_sel)
      2'd0:    gate_load_val = GATE_LOAD_R0;
      2'd1:    gate_load_val = GATE_LOAD_R1;
      2'd2:    gate_load_val = GATE_LOAD_R2;
      default: gate_load_val = GATE_LOAD_R3;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the timer is reloaded on entry to each timed state.
  // NOTE: every signal written in a combinational block gets a default
  // first, otherwise an unassigned path infers a latch.
  always_comb begin
    state_d        = state_q;
    timer_load     = 1'b0;
    timer_load_val = gate_load_val;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d        = ST_GATE;
          timer_load     = 1'b1;
          timer_load_val = gate_load_val;
        end
      end
      ST_GATE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = ST_LATCH;
          end else begin
            state_d        = ST_SETTLE;
            timer_load     = 1'b1;
            timer_load_val = SETTLE_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (!enable)            state_d = ST_IDLE;
        else if (timer_expired) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // A started latch always completes, regardless of enable.
        state_d        = ST_HOLD;
        timer_load     = 1'b1;
        timer_load_val = HOLD_LOAD;
      end
      ST_HOLD: begin
        if (timer_expired) state_d = enable ? ST_CLEAR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath decode.
  always_comb begin
    range_q_d  = (state_q == ST_CLEAR) ? range_sel : range_q;
    ovf_pend_d = ovf_pend_q;
    if (state_q == ST_CLEAR)                ovf_pend_d = 1'b0;
    else if (state_q == ST_GATE && cnt_ovf) ovf_pend_d = 1'b1;

    cnt_en_d    = (state_d == ST_GATE);
    cnt_clr_d   = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
    lock_d      = (state_d != ST_LATCH);
    meas_done_d = (state_q == ST_LATCH);

    // Displayed status changes on the edge the latch opens, using the
    // pending flag including any overflow in the final gate cycle. An
    // aborted window never reaches LATCH and leaves them untouched.
    ovf_d       = ovf;
    range_act_d = range_act;
    if (state_d == ST_LATCH && state_q != ST_LATCH) begin
      ovf_d       = ovf_pend_d;
      range_act_d = range_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_q    <= '0;
      ovf_pend_q <= 1'b0;
      cnt_en     <= 1'b0;
      cnt_clr    <= 1'b1;
      lock       <= 1'b1;
      meas_done  <= 1'b0;
      ovf        <= 1'b0;
      range_act  <= '0;
    end else begin
      range_q    <= range_q_d;
      ovf_pend_q <= ovf_pend_d;
      cnt_en     <= cnt_en_d;
      cnt_clr    <= cnt_clr_d;
      lock       <= lock_d;
      meas_done  <= meas_done_d;
      ovf        <= ovf_d;
      range_act  <= range_act_d;
    end
  end

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Self-checking bench for freq_meter_ctrl (GATE_BASE=4, SETTLE=2, HOLD=3).
// The reference model tracks a position on the measurement timeline:
// -1 idle, 0 clear, 1..G gate, then settle, latch, and hold cycles.
module tb_freq_meter_ctrl;

  localparam int GB  = 4;
  localparam int SC  = 2;
  localparam int HC  = 3;
  localparam int TWB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] range_sel;
  logic       cnt_ovf;
  logic       cnt_en, cnt_clr, lock, meas_done, ovf;
  logic [1:0] range_act;

  freq_meter_ctrl #(
    .GATE_BASE     (GB),
    .SETTLE_CYCLES (SC),
    .HOLD_CYCLES   (HC),
    .TW            (TWB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .range_sel (range_sel),
    .cnt_ovf   (cnt_ovf),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .lock      (lock),
    .meas_done (meas_done),
    .ovf       (ovf),
    .range_act (range_act)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Output vector order: {cnt_en, cnt_clr, lock, meas_done, ovf, range_act}
  localparam logic [6:0] RESET_VEC = 7'b0110000;

  typedef struct {
    logic       en;
    logic [1:0] rs;
    logic       ov;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [20];

  // Reference model state.
  int         m_pos;
  logic [1:0] m_range;
  logic       m_pend;
  logic       m_done;
  logic       d_ovf;
  logic [1:0] d_range;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gate_len(input logic [1:0] r);
    case (r)
      2'd0:    return GB;
      2'd1:    return GB * 10;
      2'd2:    return GB * 100;
      default: return GB * 1000;
    endcase
  endfunction

  task automatic model_reset();
    m_pos   = -1;
    m_range = 2'd0;
    m_pend  = 1'b0;
    m_done  = 1'b0;
    d_ovf   = 1'b0;
    d_range = 2'd0;
  endtask

  // One clock edge of the timeline with the inputs seen during that cycle.
  task automatic model_advance(input logic en, input logic [1:0] rs, input logic ov);
    int g   = gate_len(m_range);
    int old = m_pos;
    m_done = 1'b0;
    if (old < 0) begin
      if (en) m_pos = 0;
    end else if (old == 0) begin
      m_range = rs;
      m_pend  = 1'b0;
      m_pos   = en ? 1 : -1;
    end else if (old <= g) begin
      if (ov) m_pend = 1'b1;
      m_pos = en ? old + 1 : -1;
    end else if (old <= g + SC) begin
      m_pos = en ? old + 1 : -1;
    end else if (old == g + SC + 1) begin
      m_pos  = old + 1;
      m_done = 1'b1;
    end else if (old >= g + SC + 1 + HC) begin
      m_pos = en ? 0 : -1;
    end else begin
      m_pos = old + 1;
    end
    if (m_pos != old && m_pos == gate_len(m_range) + SC + 1) begin
      d_ovf   = m_pend;
      d_range = m_range;
    end
  endtask

  function automatic logic [6:0] model_vec();
    int g  = gate_len(m_range);
    int li = g + SC + 1;
    return {(m_pos >= 1 && m_pos <= g), (m_pos <= 0), (m_pos != li), m_done, d_ovf, d_range};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {cnt_en, cnt_clr, lock, meas_done, ovf, range_act};
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return cnt_en;
      1:       return lock;
      default: return cnt_clr;
    endcase
  endfunction

  // Drive inputs for one cycle, clock, and compare against the model.
  task automatic step(input logic en, input logic [1:0] rs, input logic ov);
    enable    = en;
    range_sel = rs;
    cnt_ovf   = ov;
    @(posedge clk);
    model_advance(en, rs, ov);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic step_until(input string name, input int which, input logic val,
                            input int budget, input logic [1:0] rs);
    int i = 0;
    while (sig(which) !== val && i < budget) begin
      step(1'b1, rs, 1'b0);
      i++;
    end
    check(name, sig(which), val);
  endtask

  // Counts consecutive cnt_en cycles; range_sel switches to rs_b mid-gate.
  task automatic count_gate(input logic [1:0] rs_a, input logic [1:0] rs_b, output int n);
    n = 0;
    while (cnt_en === 1'b1 && n < 5000) begin
      n++;
      step(1'b1, (n >= 10) ? rs_b : rs_a, 1'b0);
    end
  endtask

  initial begin
    int  n;
    logic saw_lock0, saw_done;

    // Two range-0 windows; overflow pulse in the second gate cycle of the
    // first window, none in the second.
    for (int i = 0; i < 20; i++) vecs[i] = '{1'b1, 2'd0, 1'b0, 7'b0};
    vecs[3].ov   = 1'b1;
    vecs[0].exp  = 7'b0110000;
    for (int i = 1; i <= 4; i++) vecs[i].exp = 7'b1010000;
    vecs[5].exp  = 7'b0010000;
    vecs[6].exp  = 7'b0010000;
    vecs[7].exp  = 7'b0000100;
    vecs[8].exp  = 7'b0011100;
    vecs[9].exp  = 7'b0010100;
    vecs[10].exp = 7'b0010100;
    vecs[11].exp = 7'b0110100;
    for (int i = 12; i <= 15; i++) vecs[i].exp = 7'b1010100;
    vecs[16].exp = 7'b0010100;
    vecs[17].exp = 7'b0010100;
    vecs[18].exp = 7'b0000000;
    vecs[19].exp = 7'b0011000;

    rst_n     = 1'b0;
    enable    = 1'b0;
    range_sel = 2'd0;
    cnt_ovf   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_vals", dut_vec(), RESET_VEC);
    #2 rst_n = 1'b1;

    // Reset state is stable while disabled.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'd0, 1'b0);
      check("idle_stable", dut_vec(), RESET_VEC);
    end

    // Basic sequence, 11-cycle period, sticky overflow then cleared.
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].en, vecs[i].rs, vecs[i].ov);
      check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
    end

    // Range 2: 400-cycle gate, range_sel change mid-gate is ignored.
    step_until("clear_r2", 2, 1'b1, 20, 2'd2);
    step_until("gate_r2", 0, 1'b1, 5, 2'd2);
    count_gate(2'd2, 2'd3, n);
    check("gate_len_r2", n, 400);
    step_until("latch_r2", 1, 1'b0, 10, 2'd0);
    check("range_act_r2", range_act, 2'd2);
    check("ovf_r2", ovf, 1'b0);

    // Abort in the third gate cycle.
    step_until("gate_abort", 0, 1'b1, 40, 2'd0);
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd3, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    check("abort_cnt_en", cnt_en, 1'b0);
    check("abort_cnt_clr", cnt_clr, 1'b1);
    saw_lock0 = 1'b0;
    saw_done  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'd0, 1'b0);
      if (lock !== 1'b1)      saw_lock0 = 1'b1;
      if (meas_done !== 1'b0) saw_done  = 1'b1;
    end
    check("abort_no_latch", saw_lock0, 1'b0);
    check("abort_no_done", saw_done, 1'b0);
    check("abort_keep_range", range_act, 2'd2);

    // Asynchronous reset in the middle of a range-1 gate.
    step_until("gate_rst", 0, 1'b1, 10, 2'd1);
    repeat (3) step(1'b1, 2'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_rst", dut_vec(), RESET_VEC);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    check("rst_hold", dut_vec(), RESET_VEC);
    step(1'b1, 2'd1, 1'b0);
    check("restart_clear", {cnt_en, cnt_clr}, 2'b01);
    step(1'b1, 2'd1, 1'b0);
    check("restart_gate", cnt_en, 1'b1);
    count_gate(2'd1, 2'd1, n);
    check("gate_len_r1", n, 40);

    // Randomized run against the timeline model.
    for (int i = 0; i < 2500; i++) begin
      int         k;
      logic       e;
      logic [1:0] r;
      e = ($urandom_range(0, 39) != 0);
      k = $urandom_range(0, 15);
      r = (k < 7) ? 2'd0 : (k < 14) ? 2'd1 : (k == 14) ? 2'd2 : 2'd3;
      step(e, r, ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
